// File: rtl/vga_timing_gen.sv
// VGA timing generator: raster counters, pixel request port, and a LAT-deep
// sync/blank pipeline so colour, sync and blank reach the DAC aligned.
module vga_timing_gen #(
  parameter int              HACTIVE = 640,
  parameter int              HFP     = 16,
  parameter int              HSYNC   = 96,
  parameter int              HBP     = 48,
  parameter int              VACTIVE = 480,
  parameter int              VFP     = 10,
  parameter int              VSYNC   = 2,
  parameter int              VBP     = 33,
  parameter logic            HPOL    = 1'b0,
  parameter logic            VPOL    = 1'b0,
  parameter int              CNTW    = 10,
  parameter int              CW      = 8,
  parameter int              LAT     = 2,
  parameter logic [CW-1:0]   BLANK   = '0
) (
  input  logic            vgaclk,
  input  logic            resetn,
  input  logic            en,
  input  logic [CW-1:0]   r_in,
  input  logic [CW-1:0]   g_in,
  input  logic [CW-1:0]   b_in,
  output logic [CNTW-1:0] x,
  output logic [CNTW-1:0] y,
  output logic            req_valid,
  output logic            sol,
  output logic            sof,
  output logic            hsync,
  output logic            vsync,
  output logic            sync_b,
  output logic            blank_n,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic [15:0]     frame_cnt
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [CNTW-1:0] H_ACT   = CNTW'(HACTIVE);
  localparam logic [CNTW-1:0] H_SS    = CNTW'(HACTIVE + HFP);
  localparam logic [CNTW-1:0] H_SE    = CNTW'(HACTIVE + HFP + HSYNC);
  localparam logic [CNTW-1:0] H_LAST  = CNTW'(HTOTAL - 1);
  localparam logic [CNTW-1:0] V_ACT   = CNTW'(VACTIVE);
  localparam logic [CNTW-1:0] V_SS    = CNTW'(VACTIVE + VFP);
  localparam logic [CNTW-1:0] V_SE    = CNTW'(VACTIVE + VFP + VSYNC);
  localparam logic [CNTW-1:0] V_LAST  = CNTW'(VTOTAL - 1);

  logic [CNTW-1:0] hcnt_r;
  logic [CNTW-1:0] vcnt_r;
  logic [15:0]     frame_cnt_r;
  logic            h_last_s;
  logic            v_last_s;
  logic            active_s;
  logic            hs_act_s;
  logic            vs_act_s;
  logic [2:0]      stage_in_s;
  logic [2:0]      stage_out_s;
  logic            hsync_r;
  logic            vsync_r;
  logic            sync_b_r;
  logic            blank_n_r;
  logic [CW-1:0]   r_r;
  logic [CW-1:0]   g_r;
  logic [CW-1:0]   b_r;

  assign h_last_s = (hcnt_r == H_LAST);
  assign v_last_s = (vcnt_r == V_LAST);
  assign active_s = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
  assign hs_act_s = (hcnt_r >= H_SS) && (hcnt_r < H_SE);
  // Vertical sync is decided per line, so its edges land on the hcnt wrap.
  assign vs_act_s = (vcnt_r >= V_SS) && (vcnt_r < V_SE);

  assign x         = hcnt_r;
  assign y         = vcnt_r;
  assign req_valid = active_s;
  assign frame_cnt = frame_cnt_r;

  // Line/frame start pulses, suppressed while the block is frozen.
  always_comb begin
    sol = 1'b0;
    sof = 1'b0;
    if (en && (hcnt_r == '0)) begin
      sol = 1'b1;
      sof = (vcnt_r == '0);
    end else begin
      sol = 1'b0;
      sof = 1'b0;
    end
  end

  // Raster counters and completed-frame counter.
  always_ff @(posedge vgaclk or negedge resetn) begin
    if (!resetn) begin
      hcnt_r      <= '0;
      vcnt_r      <= '0;
      frame_cnt_r <= 16'd0;
    end else if (en) begin
      if (h_last_s) begin
        hcnt_r <= '0;
        if (v_last_s) begin
          vcnt_r      <= '0;
          frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
          vcnt_r <= vcnt_r + CNTW'(1);
        end
      end else begin
        hcnt_r <= hcnt_r + CNTW'(1);
      end
    end
  end

  assign stage_in_s = {hs_act_s, vs_act_s, active_s};

  generate
    if (LAT == 0) begin : g_nopipe
      assign stage_out_s = stage_in_s;
    end else begin : g_pipe
      logic [2:0] pipe_r [LAT];
      // Shift register matching the pixel generator's latency.
      always_ff @(posedge vgaclk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < LAT; i++) pipe_r[i] <= 3'b000;
        end else if (en) begin
          pipe_r[0] <= stage_in_s;
          for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
        end
      end
      assign stage_out_s = pipe_r[LAT-1];
    end
  endgenerate

  // Output register: the extra clock that aligns sync/blank with colour.
  always_ff @(posedge vgaclk or negedge resetn) begin
    if (!resetn) begin
      hsync_r   <= ~HPOL;
      vsync_r   <= ~VPOL;
      sync_b_r  <= 1'b1;
      blank_n_r <= 1'b0;
      r_r       <= '0;
      g_r       <= '0;
      b_r       <= '0;
    end else if (en) begin
      hsync_r   <= stage_out_s[2] ^ ~HPOL;
      vsync_r   <= stage_out_s[1] ^ ~VPOL;
      sync_b_r  <= ~(stage_out_s[2] | stage_out_s[1]);
      blank_n_r <= stage_out_s[0];
      if (stage_out_s[0]) begin
        r_r <= r_in;
        g_r <= g_in;
        b_r <= b_in;
      end else begin
        r_r <= BLANK;
        g_r <= BLANK;
        b_r <= BLANK;
      end
    end
  end

  assign hsync   = hsync_r;
  assign vsync   = vsync_r;
  assign sync_b  = sync_b_r;
  assign blank_n = blank_n_r;
  assign r       = r_r;
  assign g       = g_r;
  assign b       = b_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a LAT=2 active-low instance and a LAT=0
// active-high instance checked each cycle against a raster-index model.
module tb_vga_timing_gen;

  logic       vgaclk = 1'b0;
  logic       resetn = 1'b1;
  logic       en     = 1'b1;
  logic [7:0] ra_in, ga_in, ba_in, rb_in, gb_in, bb_in;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       rv_a, sol_a, sof_a, hs_a, vs_a, sb_a, bn_a;
  logic       rv_b, sol_b, sof_b, hs_b, vs_b, sb_b, bn_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [15:0] fc_a, fc_b;

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;   // enabled edges since reset release
  int cyc    = 0;   // wall-clock cycles since reset release
  int lit_on = 0;
  bit chk_on = 1'b0;

  always #5 vgaclk = ~vgaclk;

  vga_timing_gen #(.HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(1),
                   .VACTIVE(4), .VFP(1), .VSYNC(2), .VBP(1),
                   .HPOL(1'b0), .VPOL(1'b0), .CNTW(10), .CW(8), .LAT(2), .BLANK(8'd0))
  ua (.vgaclk(vgaclk), .resetn(resetn), .en(en), .r_in(ra_in), .g_in(ga_in), .b_in(ba_in),
      .x(x_a), .y(y_a), .req_valid(rv_a), .sol(sol_a), .sof(sof_a), .hsync(hs_a), .vsync(vs_a),
      .sync_b(sb_a), .blank_n(bn_a), .r(r_a), .g(g_a), .b(b_a), .frame_cnt(fc_a));

  vga_timing_gen #(.HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(1),
                   .VACTIVE(4), .VFP(1), .VSYNC(2), .VBP(1),
                   .HPOL(1'b1), .VPOL(1'b1), .CNTW(10), .CW(8), .LAT(0), .BLANK(8'd0))
  ub (.vgaclk(vgaclk), .resetn(resetn), .en(en), .r_in(rb_in), .g_in(gb_in), .b_in(bb_in),
      .x(x_b), .y(y_b), .req_valid(rv_b), .sol(sol_b), .sof(sof_b), .hsync(hs_b), .vsync(vs_b),
      .sync_b(sb_b), .blank_n(bn_b), .r(r_b), .g(g_b), .b(b_b), .frame_cnt(fc_b));

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d, n %0d)", nm, act, exp, cyc, n);
    end
  endtask

  // Colour the pixel generator returns for raster index idx.
  function automatic logic [7:0] col_r(input int idx);
    return 8'(idx % 14);
  endfunction
  function automatic logic [7:0] col_g(input int idx);
    return 8'(((idx / 14) % 8) * 16 + (idx % 14));
  endfunction
  function automatic logic [7:0] col_b(input int idx);
    return 8'(idx * 37 + 5);
  endfunction

  // Output side after nn enabled edges reflects raster index nn-1-lat.
  function automatic void model_out(input int nn, input int lat, input bit ph, input bit pv,
                                    output int e_hs, output int e_vs, output int e_sb,
                                    output int e_bn, output int e_r, output int e_g, output int e_b);
    int m = nn - 1 - lat;
    int hc, vc;
    bit act = 1'b0, hsa = 1'b0, vsa = 1'b0;
    if (m >= 0) begin
      hc  = m % 14;
      vc  = (m / 14) % 8;
      act = (hc < 8) && (vc < 4);
      hsa = (hc >= 10) && (hc < 13);
      vsa = (vc >= 5) && (vc < 7);
    end
    e_hs = ph ? int'(hsa) : int'(!hsa);
    e_vs = pv ? int'(vsa) : int'(!vsa);
    e_sb = int'(!(hsa || vsa));
    e_bn = int'(act);
    e_r  = act ? int'(col_r(m)) : 0;
    e_g  = act ? int'(col_g(m)) : 0;
    e_b  = act ? int'(col_b(m)) : 0;
  endfunction

  task automatic drive();
    int ia = n - 2;
    if (ia >= 0) begin
      ra_in = col_r(ia); ga_in = col_g(ia); ba_in = col_b(ia);
    end else begin
      ra_in = 8'($urandom); ga_in = 8'($urandom); ba_in = 8'($urandom);
    end
    rb_in = col_r(n); gb_in = col_g(n); bb_in = col_b(n);
  endtask

  task automatic tick(input bit en_next);
    @(posedge vgaclk);
    if (resetn && en) n++;
    if (resetn) cyc++;
    #1;
    en = en_next;
    drive();
  endtask

  task automatic do_reset();
    lit_on = 0;
    resetn = 1'b0;
    n = 0;
    cyc = 0;
    repeat (2) @(posedge vgaclk);
    #1;
    resetn = 1'b1;
    en = 1'b1;
    drive();
  endtask

  // Single compare process: model check every cycle plus pinned literals.
  always @(negedge vgaclk) begin
    int e_hs, e_vs, e_sb, e_bn, e_r, e_g, e_b, hc, vc;
    if (chk_on) begin
      model_out(n, 2, 1'b0, 1'b0, e_hs, e_vs, e_sb, e_bn, e_r, e_g, e_b);
      chk("a_hsync", hs_a, e_hs);   chk("a_vsync", vs_a, e_vs);
      chk("a_sync_b", sb_a, e_sb);  chk("a_blank_n", bn_a, e_bn);
      chk("a_r", r_a, e_r);         chk("a_g", g_a, e_g);   chk("a_b", b_a, e_b);
      model_out(n, 0, 1'b1, 1'b1, e_hs, e_vs, e_sb, e_bn, e_r, e_g, e_b);
      chk("b_hsync", hs_b, e_hs);   chk("b_vsync", vs_b, e_vs);
      chk("b_sync_b", sb_b, e_sb);  chk("b_blank_n", bn_b, e_bn);
      chk("b_r", r_b, e_r);         chk("b_g", g_b, e_g);   chk("b_b", b_b, e_b);
      hc = n % 14;
      vc = (n / 14) % 8;
      chk("x", x_a, hc);            chk("y", y_a, vc);
      chk("x_b", x_b, hc);          chk("y_b", y_b, vc);
      chk("req_valid", rv_a, int'(hc < 8 && vc < 4));
      chk("sol", sol_a, int'(en && hc == 0));
      chk("sof", sof_a, int'(en && hc == 0 && vc == 0));
      chk("sof_b", sof_b, int'(en && hc == 0 && vc == 0));
      chk("frame_cnt", fc_a, (n / 112) % 65536);
      chk("frame_cnt_b", fc_b, (n / 112) % 65536);
      if (lit_on == 1) begin
        case (cyc)
          0:   chk("lit_sof0", sof_a, 1);
          3:   begin chk("lit_r3", r_a, 0); chk("lit_bn3", bn_a, 1); end
          10:  chk("lit_r10", r_a, 7);
          11:  begin chk("lit_bn11", bn_a, 0); chk("lit_hsb11", hs_b, 1); chk("lit_sbb11", sb_b, 0); end
          12:  chk("lit_hs12", hs_a, 1);
          13:  begin chk("lit_hs13", hs_a, 0); chk("lit_sb13", sb_a, 0); chk("lit_hsb13", hs_b, 1); end
          14:  chk("lit_hsb14", hs_b, 0);
          15:  chk("lit_hs15", hs_a, 0);
          16:  begin chk("lit_hs16", hs_a, 1); chk("lit_bn16", bn_a, 0); end
          17:  begin chk("lit_r17", r_a, 0); chk("lit_bn17", bn_a, 1); end
          24:  chk("lit_r24", r_a, 7);
          27:  chk("lit_hs27", hs_a, 0);
          60:  chk("lit_rv60", rv_a, 0);
          72:  chk("lit_vs72", vs_a, 1);
          73:  chk("lit_vs73", vs_a, 0);
          100: chk("lit_vs100", vs_a, 0);
          101: chk("lit_vs101", vs_a, 1);
          111: begin chk("lit_fc111", fc_a, 0); chk("lit_sof111", sof_a, 0); end
          112: begin chk("lit_fc112", fc_a, 1); chk("lit_sof112", sof_a, 1); end
          default: ;
        endcase
      end else if (lit_on == 2) begin
        case (cyc)
          31: chk("lit_en_hs31", hs_a, 1);
          32: chk("lit_en_hs32", hs_a, 0);
          34: chk("lit_en_hs34", hs_a, 0);
          35: chk("lit_en_hs35", hs_a, 1);
          default: ;
        endcase
      end
    end
  end

  initial begin
    drive();
    #3;
    resetn = 1'b0;
    chk_on = 1'b1;
    // Free-running from reset across two frames.
    do_reset();
    lit_on = 1;
    for (int c = 1; c < 230; c++) tick(1'b1);

    // Reset asserted between edges in cycle 50, then the sequence repeats.
    do_reset();
    lit_on = 1;
    for (int c = 1; c <= 50; c++) tick(1'b1);
    #2;
    lit_on = 0;
    resetn = 1'b0;
    n = 0;
    cyc = 0;
    #1;
    chk("rst_x", x_a, 0);        chk("rst_y", y_a, 0);
    chk("rst_hsync", hs_a, 1);   chk("rst_vsync", vs_a, 1);
    chk("rst_r", r_a, 0);        chk("rst_blank_n", bn_a, 0);
    chk("rst_hsync_b", hs_b, 0);
    repeat (2) @(posedge vgaclk);
    #1;
    resetn = 1'b1;
    en = 1'b1;
    drive();
    lit_on = 1;
    for (int c = 1; c < 120; c++) tick(1'b1);

    // Clock enable dropped for cycles 20..24.
    do_reset();
    lit_on = 2;
    for (int c = 1; c < 60; c++) tick(!(c >= 20 && c <= 24));

    // Randomised clock enable with one reset in the middle.
    do_reset();
    for (int c = 1; c < 2000; c++) begin
      if (c == 900) do_reset();
      else tick($urandom_range(0, 9) < 7);
    end

    @(negedge vgaclk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
